// File: rtl/timer_ctrl_pkg.sv
// Shared types and default widths for the timer controller slice.
package timer_ctrl_pkg;

    // Controller sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Default counter width (matches the downstream loadable counter)
    localparam int unsigned DEF_N  = 4;
    // Default prescale field width
    localparam int unsigned DEF_PW = 8;

endpackage : timer_ctrl_pkg

// File: rtl/timer_ctrl_prescale_tick.sv
// Prescaler: free-running divider that ticks once every (period+1) run cycles.
module prescale_tick
    import timer_ctrl_pkg::*;
#(
    parameter int unsigned PW = DEF_PW
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          clr,
    input  logic          run,
    input  logic [PW-1:0] period,
    output logic          tick
);

    logic [PW-1:0] pc;

    // Prescale counter: cleared on clr, counts 0..period while running, then wraps
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pc <= '0;
        end else if (clr) begin
            pc <= '0;
        end else if (run) begin
            if (pc == period) begin
                pc <= '0;
            end else begin
                pc <= pc + 1'b1;
            end
        end
    end

    // Tick on the last count of each prescale window
    always_comb begin
        tick = run && (pc == period);
    end

endmodule : prescale_tick

// File: rtl/timer_ctrl.sv
// Timer controller: accepts a start/limit/prescale command, sequences an
// external n-bit loadable counter through load and paced increments, and
// pulses done at terminal count (optionally auto-reloading).
module timer_ctrl
    import timer_ctrl_pkg::*;
#(
    parameter int unsigned n  = DEF_N,
    parameter int unsigned PW = DEF_PW
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [n-1:0]  cmd_start,
    input  logic [n-1:0]  cmd_limit,
    input  logic [PW-1:0] cmd_prescale,
    input  logic          cmd_auto,
    input  logic          abort,
    input  logic [n-1:0]  count,
    output logic          cnt_load,
    output logic [n-1:0]  cnt_load_data,
    output logic          cnt_en,
    output logic          busy,
    output logic          done
);

    state_t        state;
    state_t        state_next;
    logic [n-1:0]  start_reg;
    logic [n-1:0]  limit_reg;
    logic [PW-1:0] prescale_reg;
    logic          auto_reg;
    logic          tick;
    logic          handshake;
    logic          at_limit;

    assign handshake = cmd_valid && cmd_ready;
    assign at_limit  = (count == limit_reg);

    prescale_tick #(
        .PW (PW)
    ) u_prescale (
        .clk    (clk),
        .resetn (resetn),
        .clr    (state == LOAD),
        .run    (state == RUN),
        .period (prescale_reg),
        .tick   (tick)
    );

    // Next-state decode; abort outranks terminal detection in every busy state
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (handshake) state_next = LOAD;
            LOAD: state_next = abort ? IDLE : RUN;
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (at_limit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (abort) begin
                    state_next = IDLE;
                end else begin
                    state_next = auto_reg ? LOAD : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, command capture and registered status outputs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= IDLE;
            start_reg    <= '0;
            limit_reg    <= '0;
            prescale_reg <= '0;
            auto_reg     <= 1'b0;
            cmd_ready    <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && handshake) begin
                start_reg    <= cmd_start;
                limit_reg    <= cmd_limit;
                prescale_reg <= cmd_prescale;
                auto_reg     <= cmd_auto;
            end
            cmd_ready <= (state_next == IDLE);
            busy      <= (state_next != IDLE);
            done      <= (state_next == DONE);
        end
    end

    // Counter strobes depend on the live count and abort, so they stay combinational
    always_comb begin
        cnt_load      = (state == LOAD) && !abort;
        cnt_en        = (state == RUN) && tick && !at_limit && !abort;
        cnt_load_data = cnt_load ? start_reg : '0;
    end

endmodule : timer_ctrl

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl with a behavioural loadable counter beside it.
module tb_timer_ctrl;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_start = '0;
    logic [3:0] cmd_limit = '0;
    logic [7:0] cmd_prescale = '0;
    logic       cmd_auto = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] count;
    logic       cnt_load;
    logic [3:0] cnt_load_data;
    logic       cnt_en;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    logic [31:0] en_m, done_m, load_m, rdy_m, busy_m;
    int          viol;
    logic [3:0]  hist [32];

    always #5 clk = ~clk;

    timer_ctrl #(
        .n  (4),
        .PW (8)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_start     (cmd_start),
        .cmd_limit     (cmd_limit),
        .cmd_prescale  (cmd_prescale),
        .cmd_auto      (cmd_auto),
        .abort         (abort),
        .count         (count),
        .cnt_load      (cnt_load),
        .cnt_load_data (cnt_load_data),
        .cnt_en        (cnt_en),
        .busy          (busy),
        .done          (done)
    );

    // Downstream loadable counter
    always_ff @(posedge clk) begin
        if (!resetn)       count <= '0;
        else if (cnt_load) count <= cnt_load_data;
        else if (cnt_en)   count <= count + 4'd1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0;
        abort     = 1'b0;
        resetn    = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        #1;
    endtask

    // Issue one command at the current cycle (cycle 0 = accept) and record
    // per-cycle output bitmasks for cycles 1..ncyc.
    task automatic run_cmd(input logic [3:0] st, input logic [3:0] lim, input logic [7:0] pre,
                           input logic au, input logic hold, input int abort_at,
                           input int rst_at, input int ncyc);
        en_m = '0; done_m = '0; load_m = '0; rdy_m = '0; busy_m = '0; viol = 0;
        for (int i = 0; i < 32; i++) hist[i] = '0;
        cmd_start = st; cmd_limit = lim; cmd_prescale = pre; cmd_auto = au;
        cmd_valid = 1'b1;
        abort = (abort_at == 0);
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk);
            #1;
            if (!hold) cmd_valid = 1'b0;
            abort  = (c == abort_at);
            resetn = !(c == rst_at);
            #1;
            if (cnt_en)    en_m[c]   = 1'b1;
            if (done)      done_m[c] = 1'b1;
            if (cnt_load)  load_m[c] = 1'b1;
            if (cmd_ready) rdy_m[c]  = 1'b1;
            if (busy)      busy_m[c] = 1'b1;
            hist[c] = count;
            if (cnt_load && cnt_en) viol++;
            if (cnt_load && cnt_load_data != st) viol++;
            if (!cnt_load && cnt_load_data != 4'd0) viol++;
        end
        abort  = 1'b0;
        resetn = 1'b1;
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_load", {31'd0, cnt_load}, 32'd0);
        check("rst_en", {31'd0, cnt_en}, 32'd0);
        check("rst_ldata", {28'd0, cnt_load_data}, 32'd0);

        // 3 -> 7, prescale 0: en cycles 2..5, done at 7, idle after
        run_cmd(4'd3, 4'd7, 8'd0, 1'b0, 1'b0, -1, -1, 10);
        check("p0_en", en_m, 32'h0000_003C);
        check("p0_done", done_m, 32'h0000_0080);
        check("p0_load", load_m, 32'h0000_0002);
        check("p0_ready", rdy_m, 32'h0000_0700);
        check("p0_busy", busy_m, 32'h0000_00FE);
        check("p0_viol", viol, 32'd0);
        check("p0_final_count", {28'd0, hist[7]}, 32'd7);

        // Same command, prescale 2: en at 4,7,10,13, done at 15
        do_reset();
        run_cmd(4'd3, 4'd7, 8'd2, 1'b0, 1'b0, -1, -1, 16);
        check("p2_en", en_m, 32'h0000_2490);
        check("p2_done", done_m, 32'h0000_8000);
        check("p2_viol", viol, 32'd0);

        // Wrap 14 -> 1: counts 14,15,0,1, done at 6
        do_reset();
        run_cmd(4'd14, 4'd1, 8'd0, 1'b0, 1'b0, -1, -1, 8);
        check("wrap_en", en_m, 32'h0000_001C);
        check("wrap_done", done_m, 32'h0000_0040);
        check("wrap_c2", {28'd0, hist[2]}, 32'd14);
        check("wrap_c3", {28'd0, hist[3]}, 32'd15);
        check("wrap_c4", {28'd0, hist[4]}, 32'd0);
        check("wrap_c5", {28'd0, hist[5]}, 32'd1);

        // start == limit: no increments, done at 3
        do_reset();
        run_cmd(4'd5, 4'd5, 8'd0, 1'b0, 1'b0, -1, -1, 5);
        check("eq_en", en_m, 32'd0);
        check("eq_done", done_m, 32'h0000_0008);
        check("eq_load", load_m, 32'h0000_0002);

        // Auto-reload 0 -> 2: done every 5, reload after each, abort at 17
        do_reset();
        run_cmd(4'd0, 4'd2, 8'd0, 1'b1, 1'b0, 17, -1, 18);
        check("auto_done", done_m, 32'h0000_8420);
        check("auto_load", load_m, 32'h0001_0842);
        check("auto_en", en_m, 32'h0000_318C);
        check("auto_busy", busy_m, 32'h0003_FFFE);
        check("auto_ready", rdy_m, 32'h0004_0000);
        check("auto_viol", viol, 32'd0);

        // Abort in the 2nd RUN cycle with cmd_valid held throughout
        do_reset();
        run_cmd(4'd3, 4'd7, 8'd0, 1'b0, 1'b1, 3, -1, 6);
        cmd_valid = 1'b0;
        check("abort_en", en_m, 32'h0000_0044);
        check("abort_done", done_m, 32'd0);
        check("abort_load", load_m, 32'h0000_0022);
        check("abort_ready", rdy_m, 32'h0000_0010);
        check("abort_busy", busy_m, 32'h0000_006E);
        check("abort_viol", viol, 32'd0);

        // Abort in IDLE does not block a simultaneous handshake
        do_reset();
        run_cmd(4'd0, 4'd1, 8'd0, 1'b0, 1'b0, 0, -1, 5);
        check("idle_abort_load", load_m, 32'h0000_0002);
        check("idle_abort_done", done_m, 32'h0000_0010);

        // Reset for one edge mid-RUN: reset values next cycle, no done
        do_reset();
        run_cmd(4'd3, 4'd7, 8'd0, 1'b0, 1'b0, -1, 3, 10);
        check("mrst_en", en_m, 32'h0000_000C);
        check("mrst_done", done_m, 32'd0);
        check("mrst_load", load_m, 32'h0000_0002);
        check("mrst_ready", rdy_m, 32'h0000_07F0);
        check("mrst_busy", busy_m, 32'h0000_000E);
        check("mrst_count", {28'd0, hist[4]}, 32'd0);
        check("mrst_viol", viol, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_timer_ctrl
